safe_lock_ctrl: RTL and testbench

Keypad-entry controller for the digital safe. It collects digits, compares the entered code against the stored code, and tracks wrong attempts with a timed lockout. It drives the 2-bit lock status consumed directly by the seven-segment status display stage (01 = locked "L", 10 = unlocked "U"). Status 00 and 11 are never driven.

---
 rtl/safe_pkg.sv | 14 +
 rtl/safe_lockout_timer.sv | 33 +++
 rtl/safe_lock_ctrl.sv | 157 +++++++++++++++
 tb/tb_safe_lock_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// Shared types for the safe keypad controller and its display stage.
package safe_pkg;

    localparam logic [1:0] STATUS_LOCKED   = 2'b01;
    localparam logic [1:0] STATUS_UNLOCKED = 2'b10;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_CHECK    = 2'b01,
        ST_UNLOCKED = 2'b10,
        ST_LOCKOUT  = 2'b11
    } safe_state_t;

endpackage

// File: rtl/safe_lockout_timer.sv
// Loadable down-counter; expired_o is high while the count is zero.
module safe_lockout_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/safe_lock_ctrl.sv
// Keypad-entry safe controller with attempt counting and timed lockout.
// Define SAFE_CODE_CHANGE_EN to allow changing the code while unlocked.
module safe_lock_ctrl
    import safe_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              digit_valid,
    input  logic                              enter,
    input  logic                              lock_req,
    output logic [1:0]                        status,
    output logic                              lockout,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt
);

    localparam int BW = NUM_DIGITS * DIGIT_W;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

    safe_state_t   state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] att_q, att_d;
    logic [AW-1:0] att_inc;
    logic [1:0]    status_q;
    logic          lockout_q;
    logic [BW-1:0] code;
    logic [BW-1:0] shifted;
    logic          full;
    logic          match;
    logic          tmr_load;
    logic          tmr_expired;

`ifdef SAFE_CODE_CHANGE_EN
    logic [BW-1:0] code_q, code_d;
    assign code = code_q;
`else
    assign code = DEFAULT_CODE;
`endif

    assign full    = (cnt_q == CW'(NUM_DIGITS));
    assign match   = full && (buf_q == code);
    assign shifted = {buf_q[BW-DIGIT_W-1:0], digit_in};
    assign att_inc = att_q + AW'(1);

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        att_d    = att_q;
        tmr_load = 1'b0;
`ifdef SAFE_CODE_CHANGE_EN
        code_d   = code_q;
`endif
        unique case (state_q)
            ST_LOCKED: begin
                if (enter) begin
                    state_d = ST_CHECK;
                end else if (digit_valid && !full) begin
                    buf_d = shifted;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (match) begin
                    state_d = ST_UNLOCKED;
                    att_d   = '0;
                end else if (att_inc == AW'(MAX_ATTEMPTS)) begin
                    state_d  = ST_LOCKOUT;
                    att_d    = att_inc;
                    tmr_load = 1'b1;
                end else begin
                    state_d = ST_LOCKED;
                    att_d   = att_inc;
                end
            end
            ST_UNLOCKED: begin
                if (lock_req) begin
                    state_d = ST_LOCKED;
                    buf_d   = '0;
                    cnt_d   = '0;
`ifdef SAFE_CODE_CHANGE_EN
                end else if (enter) begin
                    if (full) begin
                        code_d = buf_q;
                    end
                    buf_d = '0;
                    cnt_d = '0;
                end else if (digit_valid && !full) begin
                    buf_d = shifted;
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            ST_LOCKOUT: begin
                if (tmr_expired) begin
                    state_d = ST_LOCKED;
                    att_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_LOCKED;
            buf_q     <= '0;
            cnt_q     <= '0;
            att_q     <= '0;
            status_q  <= STATUS_LOCKED;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            att_q     <= att_d;
            status_q  <= (state_q == ST_UNLOCKED) ? STATUS_UNLOCKED
                                                  : STATUS_LOCKED;
            lockout_q <= (state_q == ST_LOCKOUT);
        end
    end

`ifdef SAFE_CODE_CHANGE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q <= DEFAULT_CODE;
        end else begin
            code_q <= code_d;
        end
    end
`endif

    safe_lockout_timer #(
        .W(TW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(TW'(LOCKOUT_CYCLES - 1)),
        .expired_o (tmr_expired)
    );

    assign status    = status_q;
    assign lockout   = lockout_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl; exercises both SAFE_CODE_CHANGE_EN builds.
module tb_safe_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_in = '0;
    logic       digit_valid = 1'b0;
    logic       enter = 1'b0;
    logic       lock_req = 1'b0;
    logic [1:0] status;
    logic       lockout;
    logic [2:0] digit_cnt;

    int checks = 0;
    int failures = 0;

    safe_lock_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_in   (digit_in),
        .digit_valid(digit_valid),
        .enter      (enter),
        .lock_req   (lock_req),
        .status     (status),
        .lockout    (lockout),
        .digit_cnt  (digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    // Enter strobe, then wait until the result is visible (edge N+2).
    task automatic submit();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        tick();
    endtask

    task automatic code4(input logic [15:0] c);
        for (int k = 3; k >= 0; k--) press(c[k*4 +: 4]);
        submit();
    endtask

    task automatic relock();
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        tick();
    endtask

    int n;
    int bad;

    initial begin
        do_reset();
        chk("rst_status", status, 1);
        chk("rst_lockout", lockout, 0);
        chk("rst_cnt", digit_cnt, 0);

        // Correct code, with latency check
        for (int k = 1; k <= 4; k++) press(4'(k));
        chk("cnt_full", digit_cnt, 4);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        chk("lat_n", status, 1);
        tick();
        chk("lat_n1", status, 1);
        tick();
        chk("lat_n2", status, 2);
        chk("unl_lockout", lockout, 0);
        chk("unl_cnt", digit_cnt, 0);

        relock();
        chk("relock", status, 1);

        // Fifth digit dropped
        for (int k = 1; k <= 5; k++) press(4'(k));
        chk("cnt_sat", digit_cnt, 4);
        submit();
        chk("five_unlock", status, 2);
        relock();

        // Three digits: wrong attempt
        for (int k = 1; k <= 3; k++) press(4'(k));
        submit();
        chk("three_wrong", status, 1);
        chk("three_cnt", digit_cnt, 0);

        // Digit and enter in same cycle: enter wins
        for (int k = 1; k <= 3; k++) press(4'(k));
        digit_in    = 4'd4;
        digit_valid = 1'b1;
        enter       = 1'b1;
        tick();
        digit_valid = 1'b0;
        enter       = 1'b0;
        chk("same_cnt", digit_cnt, 3);
        tick();
        tick();
        chk("same_status", status, 1);
        chk("same_nolock", lockout, 0);

        // Lockout
        do_reset();
        code4(16'h1111);
        code4(16'h1111);
        chk("wrong2_nolock", lockout, 0);
        code4(16'h1111);
        chk("wrong3_lock", lockout, 1);
        n   = 0;
        bad = 0;
        for (int i = 0; i < 2000 && lockout; i++) begin
            if (status !== 2'b01) bad++;
            n++;
            if (i < 990) begin
                digit_valid = i[0];
                digit_in    = 4'(i % 10);
                enter       = (i % 7 == 3);
                lock_req    = (i % 11 == 5);
            end else begin
                digit_valid = 1'b0;
                enter       = 1'b0;
                lock_req    = 1'b0;
            end
            tick();
        end
        chk("lockout_len", n, 1000);
        chk("lockout_status", bad, 0);
        chk("post_lock_cnt", digit_cnt, 0);
        chk("post_lock_status", status, 1);
        code4(16'h1234);
        chk("post_lock_unl", status, 2);
        relock();

        // Reset during lockout clears attempts
        code4(16'h1111);
        code4(16'h1111);
        code4(16'h1111);
        tick();
        tick();
        chk("lock_again", lockout, 1);
        do_reset();
        chk("rstlk_lockout", lockout, 0);
        chk("rstlk_status", status, 1);
        chk("rstlk_cnt", digit_cnt, 0);
        code4(16'h1111);
        chk("rstlk_att0", lockout, 0);
        code4(16'h1111);
        chk("rstlk_att1", lockout, 0);
        code4(16'h1234);
        chk("rstlk_unl", status, 2);

        // Code change attempt while unlocked
        for (int k = 9; k >= 6; k--) press(4'(k));
        submit();
        chk("chg_stay", status, 2);
        chk("chg_cnt", digit_cnt, 0);
        relock();
`ifdef SAFE_CODE_CHANGE_EN
        code4(16'h1234);
        chk("chg_old_fails", status, 1);
        code4(16'h9876);
        chk("chg_new_unl", status, 2);
`else
        code4(16'h9876);
        chk("nochg_new_fails", status, 1);
        code4(16'h1234);
        chk("nochg_old_unl", status, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
